// File: rtl/ldpc_enc_ctrl.sv
// LDPC encoder frame controller: info accept, parity accumulate, parity readout.
// Latency: each accepted info bit or parity read appears on sync_out one cycle later.
// Backpressure: out_ready low freezes DATA_OUT (no address change); info input cannot be stalled.
module ldpc_enc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rate,
  input  logic        sync_in,
  input  logic        out_ready,
  output logic [3:0]  fsm_state,
  output logic [12:0] info_cnt,
  output logic        acc_ena,
  output logic [12:0] par_addr,
  output logic        par_acc_ena,
  output logic        par_rd_ena,
  output logic        sync_out,
  output logic        out_sel,
  output logic        busy,
  output logic        finish,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    DATA_IN  = 4'b0010,
    PARITY   = 4'b0100,
    DATA_OUT = 4'b1000
  } state_t;

  state_t      state;
  logic        rate_lat;
  logic        sync_dly;
  logic        sync_start;
  logic        accept;
  logic        last_info;
  logic        last_par;
  logic [12:0] info_max;
  logic [12:0] par_max;

  assign sync_start  = sync_in & ~sync_dly;
  assign info_max    = rate_lat ? 13'd6911 : 13'd4607;
  assign par_max     = rate_lat ? 13'd2303 : 13'd4607;
  assign accept      = ((state == IDLE) & sync_start) | ((state == DATA_IN) & sync_in);
  // info_cnt holds the last accepted index, so the bit being accepted now is info_cnt+1
  assign last_info   = ((info_cnt + 13'd1) == info_max);
  assign last_par    = (par_addr == par_max);

  assign fsm_state   = state;
  assign par_acc_ena = (state == PARITY);
  assign par_rd_ena  = out_ready & fsm_state[3];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rate_lat  <= 1'b0;
      sync_dly  <= 1'b0;
      info_cnt  <= 13'd0;
      par_addr  <= 13'd0;
      acc_ena   <= 1'b0;
      sync_out  <= 1'b0;
      out_sel   <= 1'b0;
      finish    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_dly  <= sync_in;
      acc_ena   <= accept;
      sync_out  <= accept | par_rd_ena;
      out_sel   <= par_rd_ena;
      finish    <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_start) begin
            rate_lat <= rate;
            info_cnt <= 13'd0;
            state    <= DATA_IN;
          end
        end
        DATA_IN: begin
          if (sync_in) begin
            info_cnt <= info_cnt + 13'd1;
            if (last_info) begin
              par_addr <= 13'd0;
              state    <= PARITY;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        PARITY: begin
          if (last_par) begin
            par_addr <= 13'd0;
            state    <= DATA_OUT;
          end else begin
            par_addr <= par_addr + 13'd1;
          end
        end
        DATA_OUT: begin
          if (par_rd_ena) begin
            if (last_par) begin
              par_addr <= 13'd0;
              finish   <= 1'b1;
              state    <= IDLE;
            end else begin
              par_addr <= par_addr + 13'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Scoreboard bench for ldpc_enc_ctrl: stimulus queues expected codeword bits, a monitor checks them.
`timescale 1ns/1ps
module tb_ldpc_enc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rate = 1'b0;
  logic        sync_in = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  fsm_state;
  logic [12:0] info_cnt;
  logic        acc_ena;
  logic [12:0] par_addr;
  logic        par_acc_ena;
  logic        par_rd_ena;
  logic        sync_out;
  logic        out_sel;
  logic        busy;
  logic        finish;
  logic        frame_err;

  ldpc_enc_ctrl dut (
    .clk(clk), .reset_n(reset_n), .rate(rate), .sync_in(sync_in), .out_ready(out_ready),
    .fsm_state(fsm_state), .info_cnt(info_cnt), .acc_ena(acc_ena), .par_addr(par_addr),
    .par_acc_ena(par_acc_ena), .par_rd_ena(par_rd_ena), .sync_out(sync_out), .out_sel(out_sel),
    .busy(busy), .finish(finish), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [12:0] idx;
    logic        fin;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0, pacc_cnt = 0, pout_cnt = 0, fin_cnt = 0, err_cnt = 0;
  int   pacc_exp = 0, rd_addr_d = 0, prev_addr = 0;
  logic prev_stall = 1'b0;
  logic rdy_toggle = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int info_n, input int par_n);
    exp_t e;
    for (int i = 0; i < info_n; i++) begin
      e.sel = 1'b0; e.idx = 13'(i); e.fin = 1'b0;
      q.push_back(e);
    end
    for (int i = 0; i < par_n; i++) begin
      e.sel = 1'b1; e.idx = 13'(i); e.fin = (i == par_n - 1);
      q.push_back(e);
    end
  endtask

  // Holds sync_in high for exactly n sampling edges; rate flips before edge flip_at.
  task automatic drive_sync(input int n, input int flip_at);
    sync_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == flip_at) rate = ~rate;
      @(posedge clk);
      #1;
    end
    sync_in = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!finish && c < 20000);
    chk({nm, "_finish_seen"}, finish, 1);
    #5;
  endtask

  task automatic end_checks(input string nm, input int a, input int p, input int o,
                            input int f, input int e);
    chk({nm, "_acc_ena_count"}, acc_cnt, a);
    chk({nm, "_par_acc_count"}, pacc_cnt, p);
    chk({nm, "_parity_out_count"}, pout_cnt, o);
    chk({nm, "_finish_count"}, fin_cnt, f);
    chk({nm, "_frame_err_count"}, err_cnt, e);
    chk({nm, "_state_idle"}, fsm_state, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_queue_left"}, q.size(), 0);
    acc_cnt = 0; pacc_cnt = 0; pout_cnt = 0; fin_cnt = 0; err_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_fsm_state"}, fsm_state, 1);
    chk({nm, "_info_cnt"}, info_cnt, 0);
    chk({nm, "_par_addr"}, par_addr, 0);
    chk({nm, "_flags"}, {acc_ena, par_acc_ena, par_rd_ena, sync_out, out_sel, busy, finish, frame_err}, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_toggle ? ~out_ready : 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pacc_exp   = 0;
        prev_stall = 1'b0;
      end else begin
        if (sync_out) begin
          chk("sync_out_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_sel", out_sel, e.sel);
            chk("finish_on_bit", finish, e.fin);
            if (!e.sel) begin
              chk("info_cnt", info_cnt, e.idx);
              chk("acc_ena_info", acc_ena, 1);
            end else begin
              chk("parity_read_addr", rd_addr_d, e.idx);
              chk("acc_ena_parity", acc_ena, 0);
            end
          end
        end else begin
          chk("finish_without_sync_out", finish, 0);
          chk("acc_ena_without_sync_out", acc_ena, 0);
        end
        if (par_acc_ena) begin
          chk("par_acc_state", fsm_state, 4);
          chk("par_acc_addr", par_addr, pacc_exp);
          pacc_exp++;
          pacc_cnt++;
        end else begin
          pacc_exp = 0;
        end
        if (prev_stall && fsm_state == 4'b1000) chk("stall_addr_hold", par_addr, prev_addr);
        prev_stall = (fsm_state == 4'b1000) && !par_rd_ena;
        prev_addr  = par_addr;
        if (par_rd_ena) rd_addr_d = par_addr;
        if (acc_ena) acc_cnt++;
        if (sync_out && out_sel) pout_cnt++;
        if (finish) fin_cnt++;
        if (frame_err) err_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int c;
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("reset");
    step();
    reset_n = 1'b1;
    repeat (3) step();

    // rate 1/2, continuous ready
    rate = 1'b0;
    push_frame(4608, 4608);
    drive_sync(4608, -1);
    chk("r0_state_parity", fsm_state, 4);
    chk("r0_busy", busy, 1);
    wait_frame("r0");
    end_checks("r0", 4608, 4608, 4608, 1, 0);

    // rate 3/4, out_ready alternating
    rdy_toggle = 1'b1;
    rate = 1'b1;
    push_frame(6912, 2304);
    drive_sync(6912, -1);
    wait_frame("r1_toggle");
    end_checks("r1_toggle", 6912, 2304, 2304, 1, 0);
    rdy_toggle = 1'b0;
    repeat (3) step();

    // short frame aborts with frame_err
    rate = 1'b0;
    push_frame(100, 0);
    drive_sync(100, -1);
    repeat (4) step();
    chk("abort_info_cnt", info_cnt, 99);
    end_checks("abort", 100, 0, 0, 0, 1);

    // spurious sync_in edge during PARITY
    rate = 1'b1;
    push_frame(6912, 2304);
    drive_sync(6912, -1);
    repeat (10) step();
    sync_in = 1'b1;
    repeat (5) step();
    sync_in = 1'b0;
    wait_frame("spurious");
    end_checks("spurious", 6912, 2304, 2304, 1, 0);

    // back-to-back frame with rate flipping mid DATA_IN
    rate = 1'b0;
    push_frame(4608, 4608);
    drive_sync(4608, 2000);
    wait_frame("rate_flip");
    end_checks("rate_flip", 4608, 4608, 4608, 1, 0);

    // reset during DATA_OUT at par_addr 1000
    rate = 1'b0;
    push_frame(4608, 4608);
    drive_sync(4608, -1);
    c = 0;
    while (!(fsm_state == 4'b1000 && par_addr == 13'd1000) && c < 20000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("reach_addr_1000", int'(c < 20000), 1);
    reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    chk("mid_reset_no_finish", fin_cnt, 0);
    chk("mid_reset_no_frame_err", err_cnt, 0);
    q.delete();
    acc_cnt = 0; pacc_cnt = 0; pout_cnt = 0; fin_cnt = 0; err_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) step();
    rate = 1'b1;
    push_frame(6912, 2304);
    drive_sync(6912, -1);
    wait_frame("post_reset");
    end_checks("post_reset", 6912, 2304, 2304, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_enc_ctrl.md
LDPC_ENC_CTRL -- requirements
Module: ldpc_enc_ctrl

Interface
REQ-001 Parameters: none; frame sizes fixed. Info length 4608 (rate 1/2) or 6912 (rate 3/4); parity length 4608 or 2304.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rate  input  1  0 = rate 1/2, 1 = rate 3/4; sampled only at frame start.
REQ-005 sync_in  input  1  high while info bits are presented, one bit per cycle.
REQ-006 out_ready  input  1  downstream accepts a parity bit this cycle.
REQ-007 fsm_state  output  4  one-hot: IDLE=0001, DATA_IN=0010, PARITY=0100, DATA_OUT=1000.
REQ-008 info_cnt  output  13  registered index of the accepted info bit.
REQ-009 acc_ena  output  1  registered; parity accumulator update for the info bit at info_cnt.
REQ-010 par_addr  output  13  parity memory address.
REQ-011 par_acc_ena  output  1  PARITY-phase running-XOR enable.
REQ-012 par_rd_ena  output  1  parity memory read strobe.
REQ-013 sync_out  output  1  registered; output codeword bit valid.
REQ-014 out_sel  output  1  registered; 0 = info pass-through, 1 = parity bit.
REQ-015 busy, finish, frame_err  output  1 each  status (see Function).

Function
REQ-016 sync_dly SHALL register sync_in; sync_start = sync_in & !sync_dly.
REQ-017 IDLE: on sync_start, latch rate into rate_lat, accept bit 0, go to DATA_IN.
REQ-018 info_max = rate_lat ? 6911 : 4607; par_max = rate_lat ? 2303 : 4607.
REQ-019 Accepted bit: sync_in high in the sync_start cycle or in DATA_IN.
REQ-020 Each accepted bit SHALL, one cycle later, assert acc_ena and sync_out with out_sel=0, info_cnt = bit index (0..info_max).
REQ-021 Accepting index info_max SHALL move to PARITY; extra high sync_in cycles are not accepted.
REQ-022 sync_in low in DATA_IN before index info_max: one-cycle frame_err pulse next cycle, go to IDLE, no PARITY/DATA_OUT.
REQ-023 PARITY: par_acc_ena high each cycle, par_addr 0..par_max ascending, then DATA_OUT with par_addr = 0; duration exactly par_max+1 cycles.
REQ-024 DATA_OUT: par_rd_ena = out_ready & fsm_state[3] (combinational); par_addr increments on each par_rd_ena.
REQ-025 sync_out = par_rd_ena delayed one cycle, out_sel=1 (one-cycle memory read latency).
REQ-026 Read at par_addr = par_max: go to IDLE, par_addr to 0. finish pulses one cycle, coincident with the final sync_out.
REQ-027 out_ready low SHALL stall DATA_OUT indefinitely with no address change.
REQ-028 busy = (fsm_state != IDLE).
REQ-029 sync_start outside IDLE is ignored; rate changes after frame start are ignored.
REQ-030 A new frame MAY start in the IDLE cycle immediately after finish.
REQ-031 Counters are 13-bit; they never exceed 6911 and never wrap.

Reset
REQ-032 reset_n low SHALL immediately force:
- fsm_state = IDLE (0001)
- all counters, rate_lat and sync_dly = 0
- all 1-bit outputs = 0
REQ-033 Reset mid-frame SHALL abandon the frame without a finish or frame_err pulse.

Verification
REQ-034 Rate 0, sync_in high for 4608 cycles, out_ready=1 -> 4608 acc_ena (info_cnt 0..4607), 4608 par_acc_ena, 4608 parity sync_out, one finish.
REQ-035 Rate 1, out_ready toggling 1/0 -> 6912 info bits, 2304 par_acc_ena, 2304 parity sync_out, par_addr stalls while out_ready=0, finish on the last bit.
REQ-036 Rate 0, sync_in high for only 100 cycles -> info_cnt reaches 99, frame_err pulses once, state IDLE, no par_acc_ena.
REQ-037 Second sync_in rising edge during PARITY -> ignored, frame completes normally, then a new frame is accepted from IDLE.
REQ-038 reset_n low during DATA_OUT at par_addr=1000 -> all outputs 0, IDLE, then a fresh rate-1 frame encodes correctly.
REQ-039 rate toggles mid-DATA_IN -> counts follow the rate sampled at frame start.
